// File: rtl/producto_a_bcd.sv
// producto_a_bcd: iterative double-dabble converter from the multiplier product to packed BCD digits
module producto_a_bcd #(
    parameter int ANCHO   = 8,
    parameter int DIGITOS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Start,
    input  logic [2*ANCHO:0]       Producto,
    output logic [4*DIGITOS-1:0]   BCD,
    output logic                   Listo,
    output logic                   Ocupado
);
    localparam int N  = 2*ANCHO+1;
    localparam int CW = $clog2(2*ANCHO+2);
    localparam int AW = 4*DIGITOS;

    typedef enum logic [1:0] {IDLE, CONVIERTE, FIN} estado_t;

    estado_t         estado_q, estado_d;
    logic [N-1:0]    bin_q, bin_d;
    logic [AW-1:0]   acc_q, acc_d, acc_adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   bcd_q, bcd_d;
    logic            listo_q, listo_d;
    logic            ocupado_q, ocupado_d;

    // add-3 correction applied independently to every digit of the accumulator
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITOS; i++)
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end

    // next-state, datapath and registered-output decode
    always_comb begin
        estado_d = estado_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        case (estado_q)
            IDLE: begin
                if (Start) begin
                    bin_d    = Producto;
                    acc_d    = '0;
                    cnt_d    = CW'(N);
                    estado_d = CONVIERTE;
                end
            end
            CONVIERTE: begin
                {acc_d, bin_d} = {acc_adj[AW-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d    = acc_d;
                    estado_d = FIN;
                end
            end
            FIN:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
        listo_d   = estado_d == FIN;
        ocupado_d = estado_d != IDLE;
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            listo_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            listo_q   <= listo_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign BCD     = bcd_q;
    assign Listo   = listo_q;
    assign Ocupado = ocupado_q;
endmodule
